// File: rtl/rf_access_ctrl_pkg.sv
// Shared opcodes, FSM states and width defaults for rf_access_ctrl.
// Define RF_ACCESS_CTRL_ADD_EN to enable opcode 101 (ADD).
package rf_access_ctrl_pkg;

    localparam int DW_DEF = 8;
    localparam int AW_DEF = 2;

    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_LDI = 3'b001;
    localparam logic [2:0] OP_MOV = 3'b010;
    localparam logic [2:0] OP_RD  = 3'b011;
    localparam logic [2:0] OP_SWL = 3'b100;
    localparam logic [2:0] OP_ADD = 3'b101;

    typedef enum logic [2:0] {
        IDLE,
        RD_SRC,
`ifdef RF_ACCESS_CTRL_ADD_EN
        RD_DST,
`endif
        WR,
        RSP
    } state_e;

    // r3 only loads from the switch bus, so data writes to it are rejected
    function automatic logic op_illegal(input logic [2:0] op,
                                        input logic dst_is_sw);
        logic ill;
        case (op)
            OP_NOP, OP_RD, OP_SWL: ill = 1'b0;
            OP_LDI, OP_MOV:        ill = dst_is_sw;
`ifdef RF_ACCESS_CTRL_ADD_EN
            OP_ADD:                ill = dst_is_sw;
`endif
            default:               ill = 1'b1;
        endcase
        return ill;
    endfunction

endpackage

// File: rtl/rf_ce_decode.sv
// One-hot write-enable decoder with enable for the register file.
module rf_ce_decode #(
    parameter int AW = 2
) (
    input  logic                 en,
    input  logic [AW-1:0]        addr,
    output logic [(1<<AW)-1:0]   ce
);

    always_comb begin
        ce = '0;
        if (en) ce[addr] = 1'b1;
    end

endmodule

// File: rtl/rf_access_ctrl.sv
// Command sequencer and sole writer of the 4x8 register file.
// Define RF_ACCESS_CTRL_ADD_EN to enable the ADD opcode and RD_DST state.
module rf_access_ctrl
    import rf_access_ctrl_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          cmd_valid,
    output logic          cmd_ready,
    input  logic [2:0]    cmd_op,
    input  logic [AW-1:0] cmd_dst,
    input  logic [AW-1:0] cmd_src,
    input  logic [DW-1:0] cmd_imm,
    output logic          rsp_valid,
    input  logic          rsp_ready,
    output logic [DW-1:0] rsp_data,
    output logic          rsp_err,
    output logic [DW-1:0] rf_data_in,
    output logic          rf_ce0,
    output logic          rf_ce1,
    output logic          rf_ce2,
    output logic          rf_ce3,
    output logic [AW-1:0] rf_addr,
    input  logic [DW-1:0] rf_data_out
);

    localparam logic [AW-1:0] SW_REG = '1;

    state_e             state_q, state_d;
    logic [2:0]         op_q;
    logic [AW-1:0]      dst_q, src_q;
    logic [DW-1:0]      imm_q, tmp_q;
    logic [DW-1:0]      rsp_data_d;
    logic               rsp_err_d;
    logic               accept, wr_en;
    logic [AW-1:0]      wr_addr;
    logic [(1<<AW)-1:0] ce;

    assign cmd_ready = rst_n && (state_q == IDLE);
    assign accept    = cmd_valid && cmd_ready;
    assign rsp_valid = (state_q == RSP);
    // rst_n gating keeps a pending write from landing on the reset edge
    assign wr_en     = rst_n && (state_q == WR);
    assign wr_addr   = (op_q == OP_SWL) ? SW_REG : dst_q;

    rf_ce_decode #(.AW(AW)) u_ce (
        .en   (wr_en),
        .addr (wr_addr),
        .ce   (ce)
    );

    assign rf_ce0 = ce[0];
    assign rf_ce1 = ce[1];
    assign rf_ce2 = ce[2];
    assign rf_ce3 = ce[3];

    always_comb begin
        rf_addr    = '0;
        rf_data_in = '0;
        unique case (state_q)
            RD_SRC:  rf_addr = (op_q == OP_SWL) ? SW_REG : src_q;
`ifdef RF_ACCESS_CTRL_ADD_EN
            RD_DST:  rf_addr = dst_q;
`endif
            WR:      rf_data_in = (op_q == OP_LDI) ? imm_q : tmp_q;
            default: ;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        rsp_data_d = '0;
        rsp_err_d  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    if (op_illegal(cmd_op, cmd_dst == SW_REG)) begin
                        state_d   = RSP;
                        rsp_err_d = 1'b1;
                    end else begin
                        case (cmd_op)
                            OP_LDI, OP_SWL: state_d = WR;
                            OP_MOV, OP_RD:  state_d = RD_SRC;
`ifdef RF_ACCESS_CTRL_ADD_EN
                            OP_ADD:         state_d = RD_SRC;
`endif
                            default:        state_d = RSP;
                        endcase
                    end
                end
            end
            RD_SRC: begin
                case (op_q)
                    OP_RD, OP_SWL: begin
                        state_d    = RSP;
                        rsp_data_d = rf_data_out;
                    end
`ifdef RF_ACCESS_CTRL_ADD_EN
                    OP_ADD:  state_d = RD_DST;
`endif
                    default: state_d = WR;
                endcase
            end
`ifdef RF_ACCESS_CTRL_ADD_EN
            RD_DST:  state_d = WR;
`endif
            WR: begin
                if (op_q == OP_SWL) begin
                    state_d = RD_SRC;
                end else begin
                    state_d    = RSP;
                    rsp_data_d = rf_data_in;
                end
            end
            RSP:     if (rsp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= OP_NOP;
            dst_q    <= '0;
            src_q    <= '0;
            imm_q    <= '0;
            tmp_q    <= '0;
            rsp_data <= '0;
            rsp_err  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                op_q  <= cmd_op;
                dst_q <= cmd_dst;
                src_q <= cmd_src;
                imm_q <= cmd_imm;
            end
            if (state_q == RD_SRC) tmp_q <= rf_data_out;
`ifdef RF_ACCESS_CTRL_ADD_EN
            if (state_q == RD_DST) tmp_q <= tmp_q + rf_data_out;
`endif
            if (state_d == RSP && state_q != RSP) begin
                rsp_data <= rsp_data_d;
                rsp_err  <= rsp_err_d;
            end
        end
    end

endmodule

// File: tb/tb_rf_access_ctrl.sv
// Scoreboard bench for rf_access_ctrl with a behavioural register file model.
module tb_rf_access_ctrl;

`ifdef RF_ACCESS_CTRL_ADD_EN
    localparam bit ADD_EN = 1'b1;
`else
    localparam bit ADD_EN = 1'b0;
`endif

    typedef struct {
        logic [7:0] data;
        bit         err;
        int         lat;
        int         acc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cmd_valid, cmd_ready, rsp_valid, rsp_ready, rsp_err;
    logic [2:0] cmd_op;
    logic [1:0] cmd_dst, cmd_src, rf_addr;
    logic [7:0] cmd_imm, rsp_data, rf_data_in, rf_data_out;
    logic       rf_ce0, rf_ce1, rf_ce2, rf_ce3;
    logic [3:0] ce;

    logic [7:0] regs [4];
    logic [7:0] ref_regs [4];
    logic [7:0] sw;

    exp_t exp_q[$];
    int   n_chk = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   ce_cnt = 0;
    int   exp_wr = 0;
    int   stall_req = 0;
    bit   pending = 0;
    bit   hs = 0;

    always #5 clk = ~clk;

    rf_access_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .cmd_valid   (cmd_valid),
        .cmd_ready   (cmd_ready),
        .cmd_op      (cmd_op),
        .cmd_dst     (cmd_dst),
        .cmd_src     (cmd_src),
        .cmd_imm     (cmd_imm),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_err     (rsp_err),
        .rf_data_in  (rf_data_in),
        .rf_ce0      (rf_ce0),
        .rf_ce1      (rf_ce1),
        .rf_ce2      (rf_ce2),
        .rf_ce3      (rf_ce3),
        .rf_addr     (rf_addr),
        .rf_data_out (rf_data_out)
    );

    assign ce = {rf_ce3, rf_ce2, rf_ce1, rf_ce0};
    assign rf_data_out = regs[rf_addr];

    task automatic chk(input bit ok, input string name,
                       input int act, input int exp);
        n_chk++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // register file: r3 loads the switch bus
    always @(posedge clk) begin
        if (!rst_n) chk(ce == 4'b0, "ce_on_reset_edge", ce, 0);
        if (rf_ce0) regs[0] <= rf_data_in;
        if (rf_ce1) regs[1] <= rf_data_in;
        if (rf_ce2) regs[2] <= rf_data_in;
        if (rf_ce3) regs[3] <= sw;
        cyc <= cyc + 1;
    end

    // response monitor
    always @(negedge clk) begin
        exp_t e;
        logic [7:0] held_d;
        bit held_e;
        int hold;
        if (!rst_n) begin
            pending = 0;
            hs = 0;
            rsp_ready = 1'b0;
        end else begin
            if (hs) begin
                chk(!rsp_valid, "rsp_drop_after_hs", rsp_valid, 0);
                pending = 0;
                hs = 0;
            end
            if (rsp_valid && !pending) begin
                chk(exp_q.size() != 0, "rsp_unexpected", 1, 0);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk(rsp_data == e.data, "rsp_data", rsp_data, e.data);
                    chk(rsp_err == e.err, "rsp_err", rsp_err, e.err);
                    chk(cyc - e.acc == e.lat, "rsp_latency",
                        cyc - e.acc, e.lat);
                end
                pending = 1;
                held_d = rsp_data;
                held_e = rsp_err;
                hold = stall_req;
            end else if (pending) begin
                chk(rsp_valid, "rsp_valid_held", rsp_valid, 1);
                chk(rsp_data == held_d, "rsp_data_stable", rsp_data, held_d);
                chk(rsp_err == held_e, "rsp_err_stable", rsp_err, held_e);
            end
            if (pending) begin
                chk(!cmd_ready, "ready_during_rsp", cmd_ready, 0);
                if (hold > 0) begin
                    hold--;
                    rsp_ready = 1'b0;
                end else begin
                    rsp_ready = 1'($urandom_range(0, 1));
                end
                hs = rsp_ready;
            end else begin
                rsp_ready = 1'b0;
            end
        end
        chk($onehot0(ce), "ce_onehot", ce, 0);
        if (ce != 4'b0) ce_cnt++;
    end

    task automatic start(input int op, input int dst, input int src,
                         input int imm, input int stall, input bit push,
                         output int acc);
        exp_t e;
        int n;
        bit ill;
        logic [7:0] a, b;
        @(negedge clk); #2;
        cmd_op = op[2:0];
        cmd_dst = dst[1:0];
        cmd_src = src[1:0];
        cmd_imm = imm[7:0];
        cmd_valid = 1'b1;
        n = 0;
        while (!cmd_ready && n < 50) begin
            @(negedge clk); #2;
            n++;
        end
        chk(cmd_ready, "cmd_accept", cmd_ready, 1);
        acc = cyc;
        ill = (op > 5) || (op == 5 && !ADD_EN) ||
              ((op == 1 || op == 2 || op == 5) && dst == 3);
        e.err = ill;
        e.data = 8'h00;
        e.lat = 1;
        e.acc = acc;
        exp_wr = 0;
        if (!ill) begin
            a = ref_regs[src];
            b = ref_regs[dst];
            case (op)
                1: begin
                    e.data = imm[7:0]; e.lat = 2; exp_wr = 1;
                    if (push) ref_regs[dst] = imm[7:0];
                end
                2: begin
                    e.data = a; e.lat = 3; exp_wr = 1;
                    if (push) ref_regs[dst] = a;
                end
                3: begin
                    e.data = a; e.lat = 2;
                end
                4: begin
                    e.data = sw; e.lat = 3; exp_wr = 1;
                    if (push) ref_regs[3] = sw;
                end
                5: begin
                    e.data = 8'((int'(a) + int'(b)) % 256);
                    e.lat = 4; exp_wr = 1;
                    if (push) ref_regs[dst] = e.data;
                end
                default: ;
            endcase
        end
        ce_cnt = 0;
        stall_req = stall;
        if (push) exp_q.push_back(e);
        @(negedge clk); #2;
        cmd_valid = 1'b0;
    endtask

    task automatic finish_cmd();
        int n;
        n = 0;
        while ((exp_q.size() != 0 || pending) && n < 100) begin
            @(negedge clk); #2;
            n++;
        end
        chk(n < 100, "rsp_timeout", n, 100);
        if (n >= 100) exp_q.delete();
        chk(ce_cnt == exp_wr, "ce_pulse_count", ce_cnt, exp_wr);
        for (int i = 0; i < 4; i++)
            chk(regs[i] == ref_regs[i], "reg_file", regs[i], ref_regs[i]);
        chk(cmd_ready, "ready_after_rsp", cmd_ready, 1);
    endtask

    task automatic run(input int op, input int dst, input int src,
                       input int imm, input int stall);
        int acc;
        start(op, dst, src, imm, stall, 1'b1, acc);
        finish_cmd();
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end

    initial begin
        int acc;
        int n;
        for (int i = 0; i < 4; i++) begin
            regs[i] = 8'h00;
            ref_regs[i] = 8'h00;
        end
        sw = 8'h00;
        cmd_valid = 1'b0;
        cmd_op = 3'd0;
        cmd_dst = 2'd0;
        cmd_src = 2'd0;
        cmd_imm = 8'h00;
        rsp_ready = 1'b0;

        repeat (3) @(negedge clk);
        chk(!cmd_ready, "ready_in_reset", cmd_ready, 0);
        chk(!rsp_valid, "valid_in_reset", rsp_valid, 0);
        rst_n = 1'b1;
        #1;
        chk(cmd_ready, "ready_after_reset", cmd_ready, 1);
        chk(rsp_data == 8'h00, "rsp_data_reset", rsp_data, 0);
        chk(!rsp_err, "rsp_err_reset", rsp_err, 0);
        chk(rf_addr == 2'd0, "rf_addr_reset", rf_addr, 0);
        chk(rf_data_in == 8'h00, "rf_data_in_reset", rf_data_in, 0);

        run(1, 1, 0, 'hA5, 0);
        run(1, 0, 0, 'h3C, 0);
        run(2, 2, 0, 0, 0);
        run(3, 0, 2, 0, 0);
        sw = 8'h5A;
        run(4, 0, 0, 0, 0);
        run(1, 3, 0, 'h99, 0);
        run(3, 0, 3, 0, 0);
        run(1, 1, 0, 'h77, 5);
        run(2, 1, 1, 0, 0);
        run(0, 0, 0, 0, 0);

        // abort a MOV in its write cycle
        run(1, 0, 0, 'h77, 0);
        run(1, 2, 0, 'h11, 0);
        start(2, 2, 0, 0, 0, 1'b0, acc);
        n = 0;
        while (cyc != acc + 2 && n < 10) begin
            @(negedge clk); #2;
            n++;
        end
        chk(cyc == acc + 2, "reach_wr", cyc, acc + 2);
        chk(ce == 4'b0100, "mov_wr_ce", ce, 4);
        rst_n = 1'b0;
        #1;
        chk(ce == 4'b0, "ce_gated_by_reset", ce, 0);
        chk(!cmd_ready, "ready_gated_by_reset", cmd_ready, 0);
        @(posedge clk); #1;
        chk(!rsp_valid, "abort_no_rsp", rsp_valid, 0);
        chk(rsp_data == 8'h00, "abort_rsp_data", rsp_data, 0);
        chk(!rsp_err, "abort_rsp_err", rsp_err, 0);
        chk(rf_data_in == 8'h00, "abort_data_in", rf_data_in, 0);
        chk(rf_addr == 2'd0, "abort_addr", rf_addr, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk(regs[2] == 8'h11, "abort_r2_kept", regs[2], 'h11);
        run(1, 1, 0, 'h42, 0);

        run(1, 0, 0, 'hF0, 0);
        run(1, 1, 0, 'h20, 0);
        run(5, 0, 1, 0, 0);
        run(6, 1, 0, 'h12, 0);
        run(7, 0, 0, 'h34, 2);

        for (int k = 0; k < 150; k++) begin
            if ($urandom_range(0, 7) == 0) sw = 8'($urandom);
            run(int'($urandom_range(0, 7)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 255)),
                int'($urandom_range(0, 3)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
